port_uart_tx: RTL
=================

Name: port_uart_tx

Overview:
- Memory-mapped serial transmitter on the CPU I/O port bus, downstream of the OUT/IN port path.
- Accepts bytes from OUT instructions and buffers them in a small FIFO.
- Shifts each byte out on a single 8N1 line at a fixed clock divider.
- Provides a status word that IN instructions can read.

Parameters:
WORD_SIZE, 16, port address/data width
BASE_ADDR, 16'h0010, address of DATA register; STATUS register at BASE_ADDR+1
CLKS_PER_BIT, 4, clock cycles per serial bit (>=2)
FIFO_LOG2, 2, log2 of FIFO depth (depth 4 by default)

Ports:
clk  input  1  system clock, all state on rising edge
do_reset  input  1  synchronous active-high reset
portaddr  input  WORD_SIZE  port address from CPU
portval  input  WORD_SIZE  port write data from CPU
portget  input  1  port read strobe (IN)
portset  input  1  port write strobe (OUT), one cycle per write
portout  output  WORD_SIZE  read data; 0 when not selected so it can be OR'd with other port devices
tx  output  1  serial line, idle high

Behaviour:
- Reset (do_reset high at a rising edge):
  - FIFO emptied; count=0.
  - FSM to IDLE; baud counter and bit index to 0.
  - overflow flag cleared; tx=1 from that edge onward.
  - Reset mid-frame aborts the frame with no stop bit; tx=1 at once.
- Writes (sampled at the rising edge with portset=1):
  - To BASE_ADDR: push portval[7:0] if count < depth (count as registered before the edge). If the FIFO is full, drop the byte and set overflow=1. Drop happens even if a pop occurs on the same edge.
  - To BASE_ADDR+1: clear overflow; data ignored.
  - Other addresses: ignored.
- Reads (combinational):
  - portget=1 and portaddr=BASE_ADDR+1: portout = {zeros, count[FIFO_LOG2:0] in bits[7:4], overflow bit3, busy bit2, full bit1, empty bit0}.
    - empty = (count==0); full = (count==depth); busy = (state!=IDLE) | !empty.
  - portget=1 and portaddr=BASE_ADDR: portout = 0 (write-only).
  - Otherwise portout = 0.
  - Reads have no side effects.
- FIFO:
  - Circular buffer with read/write pointers of FIFO_LOG2 bits; pointers wrap naturally.
  - count is FIFO_LOG2+1 bits.
  - Simultaneous accepted push and pop: count unchanged, both pointers advance.
- TX FSM: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If registered count != 0, pop head into an 8-bit shift register, clear baud counter, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, LSB first. Shift right after each bit; after bit 7 go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
  - Back-to-back bytes: IDLE lasts exactly one cycle between frames, so frame pitch is 10*CLKS_PER_BIT+1 cycles.
- Latency:
  - Push at edge N into an empty FIFO with FSM idle → count=1 after N.
  - Pop at edge N+1; tx goes low after edge N+1.
- tx is driven from a register (glitch-free).

Test Plan:
- Reset then idle 20 cycles → tx=1 throughout. STATUS read returns 16'h0001 (empty, count 0).
- OUT 16'h12A5 to 16'h0010, CLKS_PER_BIT=4 → tx low starting 2 edges after the write. Then 4-cycle bits 0,1,0,1,0,0,1,0,1,1 (start, A5 LSB-first, stop), then idle high. STATUS busy=1 during the frame, 16'h0001 after.
- Five writes 01,02,03,04,05 on consecutive cycles while idle:
  - First byte is popped on the edge after the first write, so all five are accepted.
  - A sixth write before any further pop → dropped; STATUS bit3=1, full=1, count=4.
  - Write to 16'h0011 → overflow=0.
  - Line emits 01..05 in order, frames 41 cycles apart.
- Fill FIFO to 4 with FSM in IDLE, then write on the same edge as the pop → write dropped (count seen full), overflow=1, count=3 after the edge.
- Assert do_reset for 1 cycle during DATA bit 3 of byte 16'h00FF with 2 bytes queued → tx=1 next cycle, STATUS=16'h0001, no further frames.
- IN from 16'h0010, from 16'h0012, and with portget=0 at 16'h0011 → portout=0 in every case.

Source files
------------

// File: rtl/port_uart_tx.sv
// Port-mapped 8N1 serial transmitter: OUT to BASE_ADDR queues a byte, IN from
// BASE_ADDR+1 returns FIFO/line status. The serial line is driven from a register.
module port_uart_tx #(
    parameter int                   WORD_SIZE    = 16,
    parameter logic [WORD_SIZE-1:0] BASE_ADDR    = 16'h0010,
    parameter int                   CLKS_PER_BIT = 4,
    parameter int                   FIFO_LOG2    = 2
) (
    input  logic                 clk,
    input  logic                 do_reset,
    input  logic [WORD_SIZE-1:0] portaddr,
    input  logic [WORD_SIZE-1:0] portval,
    input  logic                 portget,
    input  logic                 portset,
    output logic [WORD_SIZE-1:0] portout,
    output logic                 tx
);

    localparam int                   DEPTH       = 1 << FIFO_LOG2;
    localparam int                   CNT_W       = FIFO_LOG2 + 1;
    localparam int                   BAUD_W      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [WORD_SIZE-1:0] STATUS_ADDR = BASE_ADDR + WORD_SIZE'(1);
    localparam logic [CNT_W-1:0]     FULL_CNT    = CNT_W'(DEPTH);
    localparam logic [BAUD_W-1:0]    BAUD_LAST   = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state;
    state_t               state_n;
    logic [BAUD_W-1:0]    baud_cnt;
    logic [BAUD_W-1:0]    baud_n;
    logic [2:0]           bit_idx;
    logic [2:0]           bit_n;
    logic [7:0]           shift_q;
    logic [7:0]           shift_n;
    logic                 tx_n;

    logic [7:0]           mem [DEPTH];
    logic [FIFO_LOG2-1:0] wr_ptr;
    logic [FIFO_LOG2-1:0] rd_ptr;
    logic [CNT_W-1:0]     count;
    logic                 ovf;

    logic                 data_wr;
    logic                 stat_wr;
    logic                 empty;
    logic                 full;
    logic                 busy;
    logic                 push;
    logic                 pop;
    logic [WORD_SIZE-1:0] status;
    logic                 unused_hi;

    assign unused_hi = ^portval[WORD_SIZE-1:8];

    assign data_wr = portset && (portaddr == BASE_ADDR);
    assign stat_wr = portset && (portaddr == STATUS_ADDR);
    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign busy    = (state != IDLE) || !empty;
    // Fullness is judged on the registered count, so a pop on the same edge cannot make room.
    assign push    = data_wr && !full;
    assign pop     = (state == IDLE) && !empty;

    always_ff @(posedge clk) begin
        if (do_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (data_wr && full) begin
                ovf <= 1'b1;
            end else if (stat_wr) begin
                ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= portval[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (do_reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= 1'b1;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_n;
            bit_idx  <= bit_n;
            tx       <= tx_n;
        end
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_n;
    end

    always_comb begin
        state_n = state;
        baud_n  = baud_cnt;
        bit_n   = bit_idx;
        shift_n = shift_q;
        tx_n    = 1'b1;
        case (state)
            IDLE: begin
                if (pop) begin
                    shift_n = mem[rd_ptr];
                    baud_n  = '0;
                    state_n = START;
                end
            end
            START: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_n  = '0;
                    bit_n   = '0;
                    state_n = DATA;
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end
            DATA: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_n  = '0;
                    shift_n = {1'b0, shift_q[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                    end else begin
                        bit_n = bit_idx + 1'b1;
                    end
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end
            STOP: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_n  = '0;
                    state_n = IDLE;
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        // Line level is computed for the state being entered so tx changes on the same edge.
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[0];
            default: tx_n = 1'b1;
        endcase
    end

    always_comb begin
        status             = '0;
        status[0]          = empty;
        status[1]          = full;
        status[2]          = busy;
        status[3]          = ovf;
        status[4 +: CNT_W] = count;
        portout            = (portget && (portaddr == STATUS_ADDR)) ? status : '0;
    end

endmodule
